// File: rtl/mem_bus_arbiter.sv
// Purpose: two-requester round-robin arbiter sequencing one address cycle
//   plus four data beats on the shared 16-bit multiplexed AddrData bus.
// Latency: req high at IDLE edge k -> gnt/ADDR in cycle k+1; burst is 5 cycles,
//   followed by TURN_CYCLES idle cycles after reads and one IDLE cycle.
// Backpressure: none; a requester holds req until gnt, a granted burst always
//   completes all four beats regardless of req.
// Ports:
//   clk, resetL         clock, async active-low reset
//   req, req_rw         per-requester level request and direction (1 = read)
//   req_addr0/1         burst start addresses, sampled at grant
//   wdata0/1            write data for the current beat of the owner
//   gnt                 one-hot ownership, ADDR through BEAT4
//   beat_strobe, done   beat marker, BEAT4 pulse to owner
//   rdata, rdata_valid  registered read data and per-requester qualifier
//   AddrData, AddrValid, rw   memory controller side bus
module mem_bus_arbiter #(
  parameter int unsigned TURN_CYCLES = 1
) (
  input  logic        clk,
  input  logic        resetL,
  input  logic [1:0]  req,
  input  logic [1:0]  req_rw,
  input  logic [15:0] req_addr0,
  input  logic [15:0] req_addr1,
  input  logic [15:0] wdata0,
  input  logic [15:0] wdata1,
  output logic [1:0]  gnt,
  output logic        beat_strobe,
  output logic [15:0] rdata,
  output logic [1:0]  rdata_valid,
  output logic [1:0]  done,
  inout  wire  [15:0] AddrData,
  output logic        AddrValid,
  output logic        rw
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    BEAT1 = 3'd2,
    BEAT2 = 3'd3,
    BEAT3 = 3'd4,
    BEAT4 = 3'd5,
    TURN  = 3'd6
  } state_t;

  // TURN counts down from TURN_CYCLES-1 to 0, one cycle per count.
  localparam logic [1:0] TURN_LOAD = (TURN_CYCLES == 0) ? 2'd0 : 2'(TURN_CYCLES - 1);

  state_t      state;
  logic        last;      // most recent winner; reset to 1 so port 0 wins first
  logic        owner;
  logic        dir_q;     // latched direction of the current burst, 1 = read
  logic [15:0] addr_q;
  logic [1:0]  turn_cnt;

  logic        winner;
  logic        in_beat;
  logic [15:0] wr_dat;

  // Contention goes to the port that did not win last; a lone requester wins.
  assign winner  = (req[0] && req[1]) ? ~last : req[1];
  assign in_beat = (state == BEAT1) || (state == BEAT2) ||
                   (state == BEAT3) || (state == BEAT4);
  assign wr_dat  = owner ? wdata1 : wdata0;

  assign beat_strobe = in_beat;
  assign done        = (state == BEAT4) ? (owner ? 2'b10 : 2'b01) : 2'b00;

  // Drive enables decode the state register directly so an async reset
  // releases the bus in the same cycle.
  assign AddrData = (state == ADDR)       ? addr_q :
                    (in_beat && !dir_q)   ? wr_dat :
                                            16'hzzzz;

  always_ff @(posedge clk or negedge resetL) begin
    if (!resetL) begin
      state       <= IDLE;
      last        <= 1'b1;
      owner       <= 1'b0;
      dir_q       <= 1'b1;
      addr_q      <= 16'h0000;
      turn_cnt    <= 2'd0;
      gnt         <= 2'b00;
      AddrValid   <= 1'b0;
      rw          <= 1'b1;
      rdata       <= 16'h0000;
      rdata_valid <= 2'b00;
    end else begin
      rdata_valid <= 2'b00;
      // Read beats: capture whatever the memory drives on the edge ending the beat.
      if (in_beat && dir_q) begin
        rdata       <= AddrData;
        rdata_valid <= owner ? 2'b10 : 2'b01;
      end

      case (state)
        IDLE: begin
          if (|req) begin
            state     <= ADDR;
            owner     <= winner;
            last      <= winner;
            dir_q     <= req_rw[winner];
            addr_q    <= winner ? req_addr1 : req_addr0;
            gnt       <= winner ? 2'b10 : 2'b01;
            AddrValid <= 1'b1;
            rw        <= req_rw[winner];
          end
        end
        ADDR: begin
          state     <= BEAT1;
          AddrValid <= 1'b0;
        end
        BEAT1: state <= BEAT2;
        BEAT2: state <= BEAT3;
        BEAT3: state <= BEAT4;
        BEAT4: begin
          gnt <= 2'b00;
          rw  <= 1'b1;
          if (dir_q && (TURN_CYCLES != 0)) begin
            state    <= TURN;
            turn_cnt <= TURN_LOAD;
          end else begin
            state <= IDLE;
          end
        end
        TURN: begin
          if (turn_cnt == 2'd0) state <= IDLE;
          else                  turn_cnt <= turn_cnt - 2'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-requester round-robin arbiter that shares the multiplexed 16-bit AddrData burst bus in front of the paged memory controller. Each granted transaction is sequenced as one address cycle followed by four data beats. The arbiter drives AddrValid, rw and AddrData for address cycles and write beats, tristates the bus for read beats, and returns registered read data to the owning requester. It sits between the CPU-side requesters and the memory controller/memory pair.

## Interface
- TURN_CYCLES, 1, idle cycles inserted after a read burst before the next arbitration (legal 0–3)
- clk  input  1  rising-edge clock shared with memory controller and memory
- resetL  input  1  reset, asynchronous, active-low
- req  input  2  per-requester transaction request, level
- req_rw  input  2  per-requester direction: 1 read, 0 write; sampled at grant
- req_addr0, req_addr1  input  16  per-requester burst start address; sampled at grant
- wdata0, wdata1  input  16  per-requester write data for the current beat
- gnt  output  2  one-hot ownership, held for ADDR through BEAT4
- beat_strobe  output  1  high during each of BEAT1..BEAT4; owner advances wdata on the edge ending it
- rdata  output  16  registered read data
- rdata_valid  output  2  per-requester qualifier for rdata
- done  output  2  one-cycle pulse to the owner in BEAT4
- AddrData  inout  16  multiplexed address/data bus (tri)
- AddrValid  output  1  high only in ADDR
- rw  output  1  direction to the controller, 1 read

## Operation
- States: IDLE, ADDR, BEAT1, BEAT2, BEAT3, BEAT4, TURN.
- IDLE: if any req is high, register the winner, set gnt, latch req_rw and address, and go to ADDR. Otherwise stay in IDLE.
- Round-robin: `last` pointer resets to 1, so requester 0 wins the first contest. With both requesting, grant goes to !last. A single requester always wins. On grant, `last` is set to the winner.
- ADDR: AddrValid=1, AddrData=latched address, rw=latched direction. Next state is BEAT1.
- BEATn → BEAT(n+1). BEAT4 → TURN if read and TURN_CYCLES>0, otherwise IDLE.
- TURN: counts TURN_CYCLES cycles, then goes to IDLE. gnt=0 in TURN.
- Write beats: AddrData = wdata of owner (combinational mux).
- Read beats: AddrData released to 'z. rdata is loaded from AddrData on the edge ending each beat. rdata_valid[owner] is high in the cycle after each read beat.
- rw holds the latched direction from ADDR through BEAT4, and is 1 otherwise.
- AddrData is driven by the arbiter only in ADDR and write beats, and is 'z otherwise.
- Dropping req mid-burst is ignored: the burst always completes all 4 beats. req must stay high until gnt to be served.
- Address is passed through unmodified. Page decode and address increment are owned by the controller. An unmatched page still consumes a full burst, and read data is then 'z/X.

## Timing
- Reset (async assert, sync-safe deassert) values:
  - state=IDLE, last=1
  - gnt=0, AddrValid=0, rw=1, AddrData='z
  - beat_strobe=0, rdata=0, rdata_valid=0, done=0
- Reset mid-burst aborts immediately: bus released, no done pulse.
- Request-to-grant: req sampled high at edge k (state IDLE) gives gnt and ADDR in cycle k+1.
- Burst length is 5 cycles (ADDR + 4 beats). Minimum spacing is one IDLE cycle between bursts, plus TURN_CYCLES after reads.
- Read data: beat n is captured at the end of BEATn and is valid in the following cycle. The 4th beat is valid in TURN, or in IDLE if TURN_CYCLES=0.
- done is asserted during BEAT4, combinational from state and owner.
- Simultaneous req on both ports in IDLE: exactly one gnt. The loser is served next if it is still requesting.
- At most one gnt bit is ever high. AddrValid is never high outside ADDR.

## Test plan
- Write from port 0: req_addr0=16'h2010, rw=0, wdata0 = 16'hA001..A004 over beats → AddrValid 1 cycle with bus 16'h2010, bus carries A001..A004 in BEAT1..4, done[0] in BEAT4, memory 0x10..0x13 holds A001..A004.
- Read from port 1: req_addr1=16'h2010, rw=1 → bus is 'z from the arbiter during beats, rdata = A001..A004 with rdata_valid=2'b10 on 4 consecutive cycles, then TURN, then IDLE.
- Both req high continuously (port0 write 16'h2000, port1 read 16'h2020) → grants alternate 0,1,0,1 starting with port 0. No cycle has both gnt bits high.
- Reset mid-burst: resetL low during BEAT2 → same cycle gnt=0, AddrValid=0, AddrData='z. After release, state is IDLE and the next contest goes to port 0.
- Back-to-back read→write by port 0, TURN_CYCLES=2 → exactly 2 TURN + 1 IDLE cycles between BEAT4 and the next ADDR. No cycle has both the arbiter and the controller driving the bus.
- req0 dropped during BEAT1 → burst still completes 4 beats with done[0] pulse. The arbiter then stays in IDLE.
